// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_arbiter_pkg
// Shared constants and types for the register-file writeback arbiter.
//   RF_REG_COUNT / RF_REG_SIZE / RF_REG_PTR_SIZE : default register-file geometry
//   REQ_INIT / REQ_ALU / REQ_LSU                 : requester index in the one-hot grant vector
//   rr_ptr_e                                     : which of ALU/LSU wins the next contention
package rf_wb_arbiter_pkg;

  localparam int RF_REG_COUNT    = 32;
  localparam int RF_REG_SIZE     = 32;
  localparam int RF_REG_PTR_SIZE = 5;

  localparam int REQ_INIT = 0;
  localparam int REQ_ALU  = 1;
  localparam int REQ_LSU  = 2;
  localparam int REQ_NUM  = 3;

  typedef enum logic {
    RR_FAVOR_ALU = 1'b0,
    RR_FAVOR_LSU = 1'b1
  } rr_ptr_e;

endpackage

// File: rtl/rf_wb_arbiter_grant.sv
// wb_grant
// Combinational one-hot grant for the writeback arbiter.
// Init always wins; ALU vs LSU is fixed priority (ALU first) unless the
// RF_WB_RR_EN macro is defined, in which case a 1-bit pointer picks the winner.
// Ports:
//   init_valid, alu_valid, lsu_valid : request lines
//   ptr                              : favoured side (only with RF_WB_RR_EN)
//   grant[REQ_NUM-1:0]               : one-hot grant, indexed by REQ_INIT/REQ_ALU/REQ_LSU
module wb_grant
  import rf_wb_arbiter_pkg::*;
(
  input  logic               init_valid,
  input  logic               alu_valid,
  input  logic               lsu_valid,
`ifdef RF_WB_RR_EN
  input  rr_ptr_e            ptr,
`endif
  output logic [REQ_NUM-1:0] grant
);

  always_comb begin
    grant = '0;
    if (init_valid) begin
      grant[REQ_INIT] = 1'b1;
    end else if (alu_valid && lsu_valid) begin
`ifdef RF_WB_RR_EN
      if (ptr == RR_FAVOR_LSU) grant[REQ_LSU] = 1'b1;
      else                     grant[REQ_ALU] = 1'b1;
`else
      grant[REQ_ALU] = 1'b1;
`endif
    end else if (alu_valid) begin
      grant[REQ_ALU] = 1'b1;
    end else if (lsu_valid) begin
      grant[REQ_LSU] = 1'b1;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Arbitrates ALU, LSU and R0-init writebacks onto a single registered
// register-file write port, and tracks pending destinations in a busy
// scoreboard that stalls decode when a source register is still in flight.
// Build option: define RF_WB_RR_EN for round-robin ALU/LSU arbitration
// (default build is fixed priority ALU > LSU).
// Ports:
//   clk, reset_n                        : clock, async active-low reset
//   alu_valid/ready/dst/data            : ALU writeback request
//   lsu_valid/ready/dst/data            : load writeback request
//   init_valid/ready/data               : R0 initialisation request
//   issue_valid, issue_dst              : decode marks issue_dst pending
//   FD_insn_src_0, FD_insn_src_1        : decode source indices
//   D_stall                             : a decode source is pending
//   W_en, W_dst, W_result               : registered register-file write
//   init_R0, init_R0_data               : registered R0 init
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int REG_COUNT    = RF_REG_COUNT,
  parameter int REG_SIZE     = RF_REG_SIZE,
  parameter int REG_PTR_SIZE = RF_REG_PTR_SIZE
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [REG_PTR_SIZE-1:0] alu_dst,
  input  logic [REG_SIZE-1:0]     alu_data,
  input  logic                    lsu_valid,
  output logic                    lsu_ready,
  input  logic [REG_PTR_SIZE-1:0] lsu_dst,
  input  logic [REG_SIZE-1:0]     lsu_data,
  input  logic                    init_valid,
  output logic                    init_ready,
  input  logic [REG_SIZE-1:0]     init_data,
  input  logic                    issue_valid,
  input  logic [REG_PTR_SIZE-1:0] issue_dst,
  input  logic [REG_PTR_SIZE-1:0] FD_insn_src_0,
  input  logic [REG_PTR_SIZE-1:0] FD_insn_src_1,
  output logic                    D_stall,
  output logic                    W_en,
  output logic [REG_PTR_SIZE-1:0] W_dst,
  output logic [REG_SIZE-1:0]     W_result,
  output logic                    init_R0,
  output logic [REG_SIZE-1:0]     init_R0_data
);

  logic [REQ_NUM-1:0]      grant_p0;
  logic                    alu_xfer_p0;
  logic                    lsu_xfer_p0;
  logic                    init_xfer_p0;

  logic                    w_en_p1;
  logic [REG_PTR_SIZE-1:0] w_dst_p1;
  logic [REG_SIZE-1:0]     w_result_p1;
  logic                    init_r0_p1;
  logic [REG_SIZE-1:0]     init_data_p1;

  logic [REG_COUNT-1:0]    busy;
  logic [REG_COUNT-1:0]    busy_nxt;

`ifdef RF_WB_RR_EN
  rr_ptr_e                 ptr;
`endif

  // ---- stage p0: combinational grant ----
  wb_grant u_grant (
    .init_valid (init_valid),
    .alu_valid  (alu_valid),
    .lsu_valid  (lsu_valid),
`ifdef RF_WB_RR_EN
    .ptr        (ptr),
`endif
    .grant      (grant_p0)
  );

  // A grant is only ever issued to a valid requester, so grant == transfer.
  assign init_xfer_p0 = grant_p0[REQ_INIT];
  assign alu_xfer_p0  = grant_p0[REQ_ALU];
  assign lsu_xfer_p0  = grant_p0[REQ_LSU];

  assign init_ready = init_xfer_p0;
  assign alu_ready  = alu_xfer_p0;
  assign lsu_ready  = lsu_xfer_p0;

  // Clears come from the write currently on the port; the set is applied
  // last so a same-cycle reissue of that register keeps it pending.
  always_comb begin
    busy_nxt = busy;
    if (w_en_p1)     busy_nxt[w_dst_p1] = 1'b0;
    if (init_r0_p1)  busy_nxt[0]        = 1'b0;
    if (issue_valid) busy_nxt[issue_dst] = 1'b1;
  end

  // No bypass: a source stays stalled until the edge after its write.
  assign D_stall = busy[FD_insn_src_0] | busy[FD_insn_src_1];

  // ---- stage p1: registered write port and scoreboard ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy         <= '0;
      w_en_p1      <= 1'b0;
      w_dst_p1     <= '0;
      w_result_p1  <= '0;
      init_r0_p1   <= 1'b0;
      init_data_p1 <= '0;
`ifdef RF_WB_RR_EN
      ptr          <= RR_FAVOR_ALU;
`endif
    end else begin
      busy       <= busy_nxt;
      w_en_p1    <= alu_xfer_p0 | lsu_xfer_p0;
      init_r0_p1 <= init_xfer_p0;
      if (alu_xfer_p0) begin
        w_dst_p1    <= alu_dst;
        w_result_p1 <= alu_data;
      end else if (lsu_xfer_p0) begin
        w_dst_p1    <= lsu_dst;
        w_result_p1 <= lsu_data;
      end
      if (init_xfer_p0) init_data_p1 <= init_data;
`ifdef RF_WB_RR_EN
      if (alu_xfer_p0)      ptr <= RR_FAVOR_LSU;
      else if (lsu_xfer_p0) ptr <= RR_FAVOR_ALU;
`endif
    end
  end

  assign W_en         = w_en_p1;
  assign W_dst        = w_dst_p1;
  assign W_result     = w_result_p1;
  assign init_R0      = init_r0_p1;
  assign init_R0_data = init_data_p1;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;

  localparam int RC = RF_REG_COUNT;
  localparam int RS = RF_REG_SIZE;
  localparam int RP = RF_REG_PTR_SIZE;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          alu_valid, alu_ready, lsu_valid, lsu_ready, init_valid, init_ready;
  logic [RP-1:0] alu_dst, lsu_dst, issue_dst, src0, src1, W_dst;
  logic [RS-1:0] alu_data, lsu_data, init_data, W_result, init_R0_data;
  logic          issue_valid, D_stall, W_en, init_R0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.REG_COUNT(RC), .REG_SIZE(RS), .REG_PTR_SIZE(RP)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dst(alu_dst), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_dst(lsu_dst), .lsu_data(lsu_data),
    .init_valid(init_valid), .init_ready(init_ready), .init_data(init_data),
    .issue_valid(issue_valid), .issue_dst(issue_dst),
    .FD_insn_src_0(src0), .FD_insn_src_1(src1), .D_stall(D_stall),
    .W_en(W_en), .W_dst(W_dst), .W_result(W_result),
    .init_R0(init_R0), .init_R0_data(init_R0_data)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: set of pending registers plus the write that is
  // currently on the port; arbitration follows the priority rules directly.
  bit          m_busy [RC];
  bit          m_wen, m_init, m_favor_lsu;
  int          m_wdst;
  logic [RS-1:0] m_wres, m_idata;

  task automatic m_reset();
    foreach (m_busy[i]) m_busy[i] = 0;
    m_wen = 0; m_init = 0; m_favor_lsu = 0; m_wdst = 0; m_wres = '0; m_idata = '0;
  endtask

  // returns {lsu, alu, init}
  function automatic logic [2:0] m_winner();
    if (init_valid) return 3'b001;
    if (alu_valid && lsu_valid) begin
`ifdef RF_WB_RR_EN
      return m_favor_lsu ? 3'b100 : 3'b010;
`else
      return 3'b010;
`endif
    end
    if (alu_valid) return 3'b010;
    if (lsu_valid) return 3'b100;
    return 3'b000;
  endfunction

  // One clock with the inputs currently driven; checks readies/stall before
  // the edge and the registered outputs after it. Returns at the negedge.
  task automatic cycle();
    logic [2:0] g;
    #1;
    g = m_winner();
    chk("grant", {lsu_ready, alu_ready, init_ready}, g);
    chk("d_stall", D_stall, m_busy[src0] | m_busy[src1]);
    @(posedge clk);
    if (m_wen)  m_busy[m_wdst] = 0;
    if (m_init) m_busy[0] = 0;
    if (issue_valid) m_busy[issue_dst] = 1;
    m_wen  = g[1] | g[2];
    m_init = g[0];
    if (g[1]) begin m_wdst = alu_dst; m_wres = alu_data; m_favor_lsu = 1; end
    if (g[2]) begin m_wdst = lsu_dst; m_wres = lsu_data; m_favor_lsu = 0; end
    if (g[0]) m_idata = init_data;
    #1;
    chk("w_en", W_en, m_wen);
    if (m_wen) begin
      chk("w_dst", W_dst, m_wdst);
      chk("w_result", W_result, m_wres);
    end
    chk("init_r0", init_R0, m_init);
    if (m_init) chk("init_r0_data", init_R0_data, m_idata);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alu_valid = 0; lsu_valid = 0; init_valid = 0; issue_valid = 0;
    alu_dst = '0; lsu_dst = '0; issue_dst = '0; src0 = '0; src1 = '0;
    alu_data = '0; lsu_data = '0; init_data = '0;
  endtask

  task automatic pulse_reset();
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
    m_reset();
  endtask

  typedef struct {
    logic       iv, av, lv;
    logic [2:0] exp; // {lsu, alu, init}
  } vec_t;

  initial begin
    vec_t tbl [6];
    int   alu_wins;
    tbl[0] = '{0, 0, 0, 3'b000};
    tbl[1] = '{0, 1, 0, 3'b010};
    tbl[2] = '{0, 0, 1, 3'b100};
    tbl[3] = '{1, 0, 0, 3'b001};
    tbl[4] = '{1, 1, 0, 3'b001};
    tbl[5] = '{1, 1, 1, 3'b001};

    idle_inputs();
    reset_n = 0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    // reset state, with a request pending: readies live, nothing registered
    alu_valid = 1; alu_dst = 5'd4; alu_data = 32'h11; issue_valid = 1; issue_dst = 5'd4; src0 = 5'd4;
    #1;
    chk("rst_alu_ready", alu_ready, 1'b1);
    @(posedge clk); #1;
    chk("rst_w_en", W_en, 1'b0);
    chk("rst_w_dst", W_dst, '0);
    chk("rst_w_result", W_result, '0);
    chk("rst_init_r0", init_R0, 1'b0);
    chk("rst_init_data", init_R0_data, '0);
    chk("rst_d_stall", D_stall, 1'b0);
    @(negedge clk);
    idle_inputs();
    reset_n = 1;

    // table of grant patterns
    foreach (tbl[i]) begin
      init_valid = tbl[i].iv; alu_valid = tbl[i].av; lsu_valid = tbl[i].lv;
      alu_dst = RP'(i + 1); lsu_dst = RP'(i + 10); alu_data = 32'hA000 + i;
      lsu_data = 32'hB000 + i; init_data = 32'hC000 + i;
      #1;
      chk("tbl_grant", {lsu_ready, alu_ready, init_ready}, tbl[i].exp);
      cycle();
    end
    idle_inputs();
    cycle();

    // single ALU write, latency 1, then idle
    alu_valid = 1; alu_dst = 5'd3; alu_data = 32'h5A;
    #1; chk("alu_ready_t", alu_ready, 1'b1);
    cycle();
    chk("alu_wen_t1", W_en, 1'b1);
    chk("alu_dst_t1", W_dst, 5'd3);
    chk("alu_res_t1", W_result, 32'h5A);
    idle_inputs();
    cycle();
    chk("alu_wen_t2", W_en, 1'b0);

    // init beats ALU, ALU follows
    init_valid = 1; init_data = 32'hDEAD_BEEF; alu_valid = 1; alu_dst = 5'd6; alu_data = 32'h66;
    #1;
    chk("init_pri_ready", {init_ready, alu_ready}, 2'b10);
    cycle();
    chk("init_r0_t1", init_R0, 1'b1);
    chk("init_data_t1", init_R0_data, 32'hDEAD_BEEF);
    chk("init_wen_t1", W_en, 1'b0);
    init_valid = 0;
    #1; chk("alu_after_init", alu_ready, 1'b1);
    cycle();
    chk("alu_after_init_wen", W_en, 1'b1);
    idle_inputs();
    cycle();

    // ALU/LSU contention for 4 cycles from a fresh pointer
    pulse_reset();
    alu_valid = 1; lsu_valid = 1; alu_dst = 5'd1; lsu_dst = 5'd2;
    alu_wins = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
`ifdef RF_WB_RR_EN
      chk("rr_alu_ready", alu_ready, (c % 2) == 0);
`else
      chk("fp_alu_ready", alu_ready, 1'b1);
`endif
      if (alu_ready) alu_wins++;
      alu_data = 32'h100 + c; lsu_data = 32'h200 + c;
      cycle();
    end
`ifdef RF_WB_RR_EN
    chk("rr_alu_wins", alu_wins, 2);
`else
    chk("fp_alu_wins", alu_wins, 4);
`endif
    idle_inputs();
    cycle();

    // scoreboard: stall until the edge after the write, same-cycle reissue
    issue_valid = 1; issue_dst = 5'd5;
    cycle();
    issue_valid = 0; src1 = 5'd5;
    #1; chk("sb_stall_set", D_stall, 1'b1);
    cycle();
    alu_valid = 1; alu_dst = 5'd5; alu_data = 32'h55;
    cycle();
    alu_valid = 0;
    chk("sb_wen_5", W_en & (W_dst == 5'd5), 1'b1);
    issue_valid = 1; issue_dst = 5'd5;
    #1; chk("sb_stall_during_write", D_stall, 1'b1);
    cycle();
    issue_valid = 0;
    #1; chk("sb_reissue_keeps", D_stall, 1'b1);
    alu_valid = 1;
    cycle();
    alu_valid = 0;
    cycle();
    chk("sb_stall_cleared", D_stall, 1'b0);

    // reset in the middle of an ALU transfer
    issue_valid = 1; issue_dst = 5'd7;
    cycle();
    issue_valid = 0; src0 = 5'd7;
    alu_valid = 1; alu_dst = 5'd9; alu_data = 32'h99;
    #2;
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
    m_reset();
    alu_valid = 0;
    #1;
    chk("rst_mid_wen", W_en, 1'b0);
    chk("rst_mid_stall", D_stall, 1'b0);
    cycle();
    chk("rst_mid_wen_after", W_en, 1'b0);

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      init_valid  = ($urandom_range(0, 9) == 0);
      alu_valid   = ($urandom_range(0, 2) != 0);
      lsu_valid   = ($urandom_range(0, 2) != 0);
      alu_dst     = RP'($urandom);
      lsu_dst     = RP'($urandom);
      alu_data    = $urandom;
      lsu_data    = $urandom;
      init_data   = $urandom;
      issue_valid = ($urandom_range(0, 1) != 0);
      issue_dst   = RP'($urandom);
      src0        = RP'($urandom);
      src1        = RP'($urandom);
      cycle();
    end
    idle_inputs();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
